// File: rtl/la_buffer_ctrl.sv
// Circular sample-buffer pointer/occupancy controller with a 5-register window on the daisy-chained bus.
// Strobes act at the next edge; bus is a 1-cycle registered pass-through.
module la_buffer_ctrl #(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            acquire_i,
    input  logic                            pop_i,
    input  logic                            clear_i,
    output logic [$clog2(SAMPLE_DEPTH):0]   size_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic                            bram_we_o,
    output logic [$clog2(SAMPLE_DEPTH)-1:0] bram_waddr_o,
    output logic [$clog2(SAMPLE_DEPTH)-1:0] bram_raddr_o,
    input  logic [15:0]                     addr_i,
    input  logic [15:0]                     wdata_i,
    input  logic [15:0]                     rdata_i,
    input  logic                            rw_i,
    input  logic                            valid_i,
    output logic [15:0]                     addr_o,
    output logic [15:0]                     wdata_o,
    output logic [15:0]                     rdata_o,
    output logic                            rw_o,
    output logic                            valid_o
);
    localparam int AW = $clog2(SAMPLE_DEPTH);
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] DEPTH = SW'(SAMPLE_DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(SAMPLE_DEPTH - 1);
    localparam logic [15:0]   BASE  = 16'(BASE_ADDR);

    logic [AW-1:0] head, tail, offset, raddr_nxt;
    logic [SW-1:0] size, raddr_sum;
    logic [1:0]    status;
    logic          full, empty, we, pop_ok, ovf_set, udf_set;
    logic [15:0]   rel, rd_val;
    logic          sel, wr_off, wr_stat;

    // Depth need not be a power of two, so wrap by compare.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (size == DEPTH);
        empty   = (size == '0);
        // With pop alongside, a full buffer still writes: sliding window.
        we      = acquire_i && !clear_i && (!full || pop_i);
        pop_ok  = pop_i && !clear_i && !empty;
        ovf_set = acquire_i && !pop_i && full && !clear_i;
        udf_set = pop_i && !acquire_i && empty && !clear_i;

        rel     = addr_i - BASE;
        sel     = valid_i && (rel <= 16'd4);
        wr_off  = sel && rw_i && (rel[2:0] == 3'd3);
        wr_stat = sel && rw_i && (rel[2:0] == 3'd4);
        rd_val  = 16'd0;
        case (rel[2:0])
            3'd0:    rd_val = 16'(size);
            3'd1:    rd_val = 16'(tail);
            3'd2:    rd_val = 16'(head);
            3'd3:    rd_val = 16'(offset);
            3'd4:    rd_val = 16'(status);
            default: rd_val = 16'd0;
        endcase

        raddr_sum = {1'b0, tail} + {1'b0, offset};
        raddr_nxt = (raddr_sum >= DEPTH) ? AW'(raddr_sum - DEPTH) : raddr_sum[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            size         <= '0;
            offset       <= '0;
            status       <= '0;
            bram_raddr_o <= '0;
        end else begin
            if (clear_i) begin
                head <= '0;
                tail <= '0;
                size <= '0;
            end else begin
                if (we)     head <= wrap_inc(head);
                if (pop_ok) tail <= wrap_inc(tail);
                if (we && !pop_ok)      size <= size + 1'b1;
                else if (!we && pop_ok) size <= size - 1'b1;
            end
            if (wr_off)
                offset <= (wdata_i >= 16'(SAMPLE_DEPTH)) ? LAST : wdata_i[AW-1:0];
            // A flag raised this cycle survives a same-cycle status write.
            if (clear_i) status <= '0;
            else         status <= (wr_stat ? 2'b00 : status) | {udf_set, ovf_set};
            bram_raddr_o <= raddr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_o  <= '0;
            wdata_o <= '0;
            rdata_o <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
            rdata_o <= (sel && !rw_i) ? rd_val : rdata_i;
        end
    end

    assign bram_we_o    = we;
    assign bram_waddr_o = head;
    assign size_o       = size;
    assign full_o       = full;
    assign empty_o      = empty;
endmodule

// File: tb/tb_la_buffer_ctrl.sv
// Bench for la_buffer_ctrl: directed scenarios plus random strobes/bus traffic against a queue-free arithmetic model.
module tb_la_buffer_ctrl;
    localparam int D    = 8;
    localparam int BASE = 16'h10;

    logic        clk = 0, rst = 1;
    logic        acquire = 0, pop = 0, clear = 0;
    logic [3:0]  size;
    logic        full, empty, bram_we;
    logic [2:0]  bram_waddr, bram_raddr;
    logic [15:0] addr_in = 0, wdata_in = 0, rdata_in = 0;
    logic        rw_in = 0, valid_in = 0;
    logic [15:0] addr_out, wdata_out, rdata_out;
    logic        rw_out, valid_out;

    la_buffer_ctrl #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .acquire_i(acquire), .pop_i(pop), .clear_i(clear),
        .size_o(size), .full_o(full), .empty_o(empty), .bram_we_o(bram_we),
        .bram_waddr_o(bram_waddr), .bram_raddr_o(bram_raddr),
        .addr_i(addr_in), .wdata_i(wdata_in), .rdata_i(rdata_in), .rw_i(rw_in), .valid_i(valid_in),
        .addr_o(addr_out), .wdata_o(wdata_out), .rdata_o(rdata_out), .rw_o(rw_out), .valid_o(valid_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    // Reference model state (plain integers, modular arithmetic).
    int m_head, m_tail, m_size, m_off, m_stat;
    // Values captured/predicted by tick for the tests to compare.
    logic        obs_we;
    logic [2:0]  obs_waddr;
    int          exp_we, exp_waddr, exp_raddr;
    logic [15:0] exp_rdata, exp_addr, exp_wdata;
    logic        exp_rw, exp_valid;

    function automatic void model_reset();
        m_head = 0; m_tail = 0; m_size = 0; m_off = 0; m_stat = 0;
    endfunction

    // One clock: drive strobes and a bus beat, predict, advance, return at posedge+1 with inputs idle.
    task automatic tick(input logic a, input logic p, input logic c,
                        input logic bv, input logic brw, input logic [15:0] ba, input logic [15:0] bwd);
        logic [15:0] brd;
        int r, regv, sets;
        bit hit;
        brd = 16'($urandom);
        acquire = a; pop = p; clear = c;
        valid_in = bv; rw_in = brw; addr_in = ba; wdata_in = bwd; rdata_in = brd;
        #1;
        obs_we = bram_we; obs_waddr = bram_waddr;
        exp_waddr = m_head;
        exp_raddr = (m_tail + m_off) % D;
        r   = int'(ba) - BASE;
        hit = bv && r >= 0 && r <= 4;
        case (r)
            0: regv = m_size;
            1: regv = m_tail;
            2: regv = m_head;
            3: regv = m_off;
            default: regv = m_stat;
        endcase
        exp_rdata = (hit && !brw) ? 16'(regv) : brd;
        exp_addr = ba; exp_wdata = bwd; exp_rw = brw; exp_valid = bv;
        exp_we = 0; sets = 0;
        if (c) begin
            m_head = 0; m_tail = 0; m_size = 0;
        end else if (a && p) begin
            exp_we = 1;
            m_head = (m_head + 1) % D;
            if (m_size == 0) m_size = 1;
            else m_tail = (m_tail + 1) % D;
        end else if (a) begin
            if (m_size == D) sets = 1;
            else begin exp_we = 1; m_head = (m_head + 1) % D; m_size++; end
        end else if (p) begin
            if (m_size == 0) sets = 2;
            else begin m_tail = (m_tail + 1) % D; m_size--; end
        end
        if (hit && brw && r == 3) m_off = (int'(bwd) >= D) ? D - 1 : int'(bwd);
        if (c) m_stat = 0;
        else begin
            if (hit && brw && r == 4) m_stat = 0;
            m_stat = m_stat | sets;
        end
        @(posedge clk); #1;
        acquire = 0; pop = 0; clear = 0; valid_in = 0; rw_in = 0;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic bus_rd(input int a);
        tick(0, 0, 0, 1, 0, 16'(a), 16'h0);
    endtask

    task automatic bus_wr(input int a, input int d);
        tick(0, 0, 0, 1, 1, 16'(a), 16'(d));
    endtask

    task automatic test_reset();
        rst = 1; #3;
        n_cmp++;
        if (size !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || bram_we !== 1'b0 || bram_raddr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: size=%0d empty=%b full=%b we=%b raddr=%0d, need 0/1/0/0/0",
                     size, empty, full, bram_we, bram_raddr);
        end
        n_cmp++;
        if ({addr_out, wdata_out, rdata_out, rw_out, valid_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h wdata=%h rdata=%h rw=%b valid=%b, need all 0",
                     addr_out, wdata_out, rdata_out, rw_out, valid_out);
        end
        #4 rst = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            tick(1, 0, 0, 0, 0, 16'h0, 16'h0);
            n_cmp++;
            if (obs_we !== 1'b1 || obs_waddr !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_write[%0d]: we=%b waddr=%0d, need 1/%0d", i, obs_we, obs_waddr, i);
            end
        end
        n_cmp++;
        if (size !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: size=%0d full=%b empty=%b, need 8/1/0", size, full, empty);
        end
        tick(1, 0, 0, 0, 0, 16'h0, 16'h0);
        n_cmp++;
        if (obs_we !== 1'b0 || size !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_overflow_write: we=%b size=%0d, need 0/8", obs_we, size);
        end
        bus_rd(BASE + 4);
        n_cmp++;
        if (rdata_out !== 16'd1) begin
            n_fail++;
            $display("FAIL fill_overflow_status: got %0d, need 1", rdata_out);
        end
    endtask

    task automatic test_sliding();
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 0, 0, 0, 16'h0, 16'h0);
            n_cmp++;
            if (obs_we !== 1'b1 || obs_waddr !== 3'(i)) begin
                n_fail++;
                $display("FAIL slide_write[%0d]: we=%b waddr=%0d, need 1/%0d", i, obs_we, obs_waddr, i);
            end
        end
        n_cmp++;
        if (size !== 4'd8 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL slide_size: size=%0d full=%b, need 8/1", size, full);
        end
        bus_rd(BASE + 1);
        n_cmp++;
        if (rdata_out !== 16'd5) begin n_fail++; $display("FAIL slide_tail: got %0d, need 5", rdata_out); end
        bus_rd(BASE + 2);
        n_cmp++;
        if (rdata_out !== 16'd5) begin n_fail++; $display("FAIL slide_head: got %0d, need 5", rdata_out); end
    endtask

    task automatic test_underflow();
        tick(0, 0, 1, 0, 0, 16'h0, 16'h0);
        tick(0, 1, 0, 0, 0, 16'h0, 16'h0);
        n_cmp++;
        if (size !== 4'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_size: size=%0d empty=%b, need 0/1", size, empty);
        end
        bus_rd(BASE + 4);
        n_cmp++;
        if (rdata_out !== 16'd2) begin n_fail++; $display("FAIL underflow_status: got %0d, need 2", rdata_out); end
        tick(1, 1, 0, 0, 0, 16'h0, 16'h0);
        bus_rd(BASE + 4);
        n_cmp++;
        if (size !== 4'd1 || rdata_out !== 16'd2) begin
            n_fail++;
            $display("FAIL empty_acq_pop: size=%0d status=%0d, need 1/2", size, rdata_out);
        end
        bus_wr(BASE + 4, 16'hFFFF);
        bus_rd(BASE + 4);
        n_cmp++;
        if (rdata_out !== 16'd0) begin n_fail++; $display("FAIL status_clear: got %0d, need 0", rdata_out); end
    endtask

    task automatic test_readback();
        tick(0, 0, 1, 0, 0, 16'h0, 16'h0);
        repeat (7) tick(1, 0, 0, 0, 0, 16'h0, 16'h0);
        repeat (6) tick(0, 1, 0, 0, 0, 16'h0, 16'h0);
        bus_wr(BASE + 3, 3);
        idle();
        n_cmp++;
        if (bram_raddr !== 3'd1) begin
            n_fail++;
            $display("FAIL readback_raddr: got %0d, need 1", bram_raddr);
        end
        bus_wr(BASE + 3, 20);
        bus_rd(BASE + 3);
        n_cmp++;
        if (rdata_out !== 16'd7) begin n_fail++; $display("FAIL offset_saturate: got %0d, need 7", rdata_out); end
        bus_wr(BASE + 3, 0);
    endtask

    task automatic test_clear();
        tick(0, 0, 1, 0, 0, 16'h0, 16'h0);
        repeat (5) tick(1, 0, 0, 0, 0, 16'h0, 16'h0);
        tick(1, 1, 1, 0, 0, 16'h0, 16'h0);
        n_cmp++;
        if (obs_we !== 1'b0 || size !== 4'd0 || bram_waddr !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_priority: we=%b size=%0d head=%0d, need 0/0/0", obs_we, size, bram_waddr);
        end
        bus_rd(BASE + 1);
        n_cmp++;
        if (rdata_out !== 16'd0) begin n_fail++; $display("FAIL clear_tail: got %0d, need 0", rdata_out); end
    endtask

    task automatic test_async_reset();
        repeat (4) tick(1, 0, 0, 0, 0, 16'h0, 16'h0);
        n_cmp++;
        if (size !== 4'd4) begin n_fail++; $display("FAIL pre_reset_size: got %0d, need 4", size); end
        #3 rst = 1;
        #1;
        n_cmp++;
        if (size !== 4'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: size=%0d empty=%b, need 0/1", size, empty);
        end
        #2 rst = 0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1, 1'(i), 16'h30, 16'($urandom));
            n_cmp++;
            if (addr_out !== exp_addr || wdata_out !== exp_wdata || rdata_out !== exp_rdata ||
                rw_out !== exp_rw || valid_out !== exp_valid) begin
                n_fail++;
                $display("FAIL passthru[%0d]: addr=%h wdata=%h rdata=%h rw=%b valid=%b, need %h/%h/%h/%b/%b",
                         i, addr_out, wdata_out, rdata_out, rw_out, valid_out,
                         exp_addr, exp_wdata, exp_rdata, exp_rw, exp_valid);
            end
        end
    endtask

    task automatic test_random();
        logic a, p, c, bv, brw;
        logic [15:0] ba, bwd;
        for (int i = 0; i < 400; i++) begin
            a   = 1'($urandom_range(0, 1));
            p   = ($urandom_range(0, 2) == 0);
            c   = ($urandom_range(0, 24) == 0);
            bv  = 1'($urandom_range(0, 1));
            brw = ($urandom_range(0, 3) == 0);
            ba  = 16'($urandom_range(BASE - 2, BASE + 6));
            bwd = 16'($urandom_range(0, 12));
            tick(a, p, c, bv, brw, ba, bwd);
            n_cmp++;
            if (obs_we !== 1'(exp_we) || obs_waddr !== 3'(exp_waddr)) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: we=%b waddr=%0d, need %0d/%0d", i, obs_we, obs_waddr, exp_we, exp_waddr);
            end
            n_cmp++;
            if (size !== 4'(m_size) || full !== (m_size == D) || empty !== (m_size == 0) ||
                bram_raddr !== 3'(exp_raddr)) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: size=%0d full=%b empty=%b raddr=%0d, need size %0d raddr %0d",
                         i, size, full, empty, bram_raddr, m_size, exp_raddr);
            end
            n_cmp++;
            if (rdata_out !== exp_rdata || addr_out !== exp_addr || valid_out !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_bus[%0d]: rdata=%h addr=%h valid=%b, need %h/%h/%b",
                         i, rdata_out, addr_out, valid_out, exp_rdata, exp_addr, exp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_sliding();
        test_underflow();
        test_readback();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
